mp_add_seq: RTL and testbench
=============================

Name: mp_add_seq

Overview:
- Multi-precision add/subtract sequencer around one shared 32-bit carry-skip adder word stage.
- Accepts operands least-significant word first over a valid/ready stream.
- Chains the carry between words in a register and emits one registered sum word per accepted operand pair.
- Sits between a bus-side operand buffer and the result buffer of the arithmetic unit; runs 32..256-bit operations on a single 32-bit adder.

Parameters:
- WORD_W, 32, adder word width; only 32 is supported.
- MAX_WORDS, 8, maximum words per operation.
- CNT_W, $clog2(MAX_WORDS+1), width of word-count fields.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request to begin an operation
- n_words  in  CNT_W  word count, sampled on accepted start
- sub  in  1  0=A+B, 1=A-B; sampled on accepted start
- busy  out  1  operation in progress
- cfg_err  out  1  one-cycle pulse: start rejected
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer accepts operand pair
- in_a  in  WORD_W  operand A word
- in_b  in  WORD_W  operand B word
- out_valid  out  1  sum word valid
- out_ready  in  1  downstream accepts sum word
- out_sum  out  WORD_W  sum word
- out_last  out  1  marks final word of the operation
- done  out  1  one-cycle pulse after the last word is accepted downstream
- carry_out  out  1  final carry, held until the next accepted start
- ovf  out  1  signed overflow of the full-width result (see Optional Feature)

Behaviour:
- Reset values (rst_n low at a clock edge): state=IDLE; busy, cfg_err, in_ready, out_valid, out_last, done, carry_out, ovf = 0; out_sum=0; carry register and word counter = 0.
- Reset asserted mid-operation aborts immediately. Held output and partial carry are discarded; no done pulse.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start with 1<=n_words<=MAX_WORDS: latch n_words and sub, go to RUN.
  - Carry register loads sub (Cin=1 for subtract); carry_out and ovf clear.
  - start with n_words=0 or n_words>MAX_WORDS: cfg_err pulses high the next cycle, state stays IDLE.
- start while busy is ignored; no cfg_err.
- RUN:
  - in_ready = (words_left!=0) && (!out_valid || out_ready).
  - Transfer occurs when in_valid && in_ready.
  - On transfer:
    - out_sum <= in_a + (sub ? ~in_b : in_b) + carry, computed over WORD_W+1 bits.
    - carry <= bit WORD_W of that sum.
    - out_valid <= 1 on the next cycle.
    - words_left decrements.
    - out_last <= (words_left==1).
  - Latency: 1 cycle from transfer to out_valid. Throughput: 1 word/cycle when out_ready is held high.
  - The output register holds out_sum and out_last stable while out_valid && !out_ready.
  - A simultaneous new transfer and downstream accept in the same cycle replaces the output word with no bubble.
  - Transferring the last word moves the FSM to DRAIN.
- DRAIN:
  - in_ready=0.
  - When out_valid && out_ready && out_last: out_valid <= 0, carry_out <= carry, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in RUN, DRAIN and DONE.
- carry_out in subtract mode is the no-borrow flag: 1 means A>=B unsigned.
- A start in the same cycle as a done pulse is ignored; busy is still high.

Optional Feature:
- Macro: MP_ADD_OVF_EN.
- Defined: on the last-word transfer, ovf <= (a_msb == b_eff_msb) && (sum_msb != a_msb), where b_eff is in_b or ~in_b. ovf updates with carry_out and is held until the next accepted start.
- Not defined: ovf is tied to 0 and no overflow logic is synthesized.

Decomposition:
- Package mp_add_pkg:
  - state enum typedef (IDLE, RUN, DRAIN, DONE)
  - WORD_W constant
  - MAX_WORDS default
- One sub-module, mp_add_word: combinational WORD_W carry-skip adder stage (4-bit ripple blocks with block-propagate skip muxes).
  - Inputs: a, b, cin. Outputs: sum, cout.
  - B inversion stays in the sequencer.

Test Plan:
- Single-word add: n_words=1, sub=0, A=0xFFFFFFFF, B=0x00000001 -> out_sum=0x00000000, out_last=1, carry_out=1, done pulse.
- 64-bit carry chain: n_words=2, A={0x00000000,0xFFFFFFFF}, B={0x00000000,0x00000001} (LSW last) -> sums 0x00000000 then 0x00000001, carry_out=0.
- 96-bit subtract with borrow: n_words=3, sub=1, A=1, B=2 -> all three words 0xFFFFFFFF, carry_out=0. With MP_ADD_OVF_EN defined: ovf=0.
- Backpressure: n_words=4, out_ready low 3 cycles mid-stream -> in_ready drops, out_sum held stable, no word lost or duplicated, 4 words in order.
- Config error: start with n_words=0, then n_words=9 -> cfg_err pulses twice, busy stays 0.
- Overflow and reset: with MP_ADD_OVF_EN, n_words=1, A=0x7FFFFFFF, B=1 -> ovf=1.
  - Then start n_words=4 and assert rst_n=0 after 2 words -> all outputs return to reset values, no done pulse.

Source files
------------

// File: rtl/mp_add_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
package mp_add_pkg;

    localparam int WORD_W        = 32;
    localparam int DEF_MAX_WORDS = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/mp_add_word.sv
// One WORD_W-bit carry-skip adder stage: 4-bit ripple blocks whose carry-in
// bypasses the block through a mux whenever every bit of the block propagates.
module mp_add_word
    import mp_add_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout
);

    localparam int BLK_W = 4;
    localparam int N_BLK = WORD_W / BLK_W;

    // NOTE: combinational logic uses blocking '=' so each loop step sees the
    // carry produced by the previous one; every output gets a default first.
    always_comb begin
        logic c_skip;
        logic c_rip;
        logic prop;
        sum    = '0;
        c_skip = cin;
        for (int k = 0; k < N_BLK; k++) begin
            c_rip = c_skip;
            prop  = 1'b1;
            for (int j = 0; j < BLK_W; j++) begin
                sum[k*BLK_W+j] = a[k*BLK_W+j] ^ b[k*BLK_W+j] ^ c_rip;
                c_rip = (a[k*BLK_W+j] & b[k*BLK_W+j]) |
                        ((a[k*BLK_W+j] ^ b[k*BLK_W+j]) & c_rip);
                prop  = prop & (a[k*BLK_W+j] ^ b[k*BLK_W+j]);
            end
            c_skip = prop ? c_skip : c_rip;
        end
        cout = c_skip;
    end

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: LSW-first operand stream through one
// shared word adder. Define MP_ADD_OVF_EN to build the signed-overflow flag.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int MAX_WORDS = DEF_MAX_WORDS,
    parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  n_words,
    input  logic              sub,
    output logic              busy,
    output logic              cfg_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_a,
    input  logic [WORD_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_sum,
    output logic              out_last,
    output logic              done,
    output logic              carry_out,
    output logic              ovf
);

    state_t            state;
    logic              sub_q;
    logic              carry;
    logic [CNT_W-1:0]  words_left;
    logic [WORD_W-1:0] b_eff;
    logic [WORD_W-1:0] sum_w;
    logic              cout_w;
    logic              xfer;

    assign b_eff    = sub_q ? ~in_b : in_b;
    assign in_ready = (state == RUN) && (words_left != '0) && (!out_valid || out_ready);
    assign xfer     = in_valid && in_ready;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    mp_add_word u_word (
        .a    (in_a),
        .b    (b_eff),
        .cin  (carry),
        .sum  (sum_w),
        .cout (cout_w)
    );

`ifdef MP_ADD_OVF_EN
    // Overflow is captured with the last word but only published with carry_out.
    logic ovf_pend;
    logic ovf_q;
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values; the reset branch is synchronous, inside the clocked block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sub_q      <= 1'b0;
            carry      <= 1'b0;
            words_left <= '0;
            cfg_err    <= 1'b0;
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_last   <= 1'b0;
            carry_out  <= 1'b0;
`ifdef MP_ADD_OVF_EN
            ovf_pend   <= 1'b0;
            ovf_q      <= 1'b0;
`endif
        end else begin
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (n_words == '0 || n_words > CNT_W'(MAX_WORDS)) begin
                            cfg_err <= 1'b1;
                        end else begin
                            sub_q      <= sub;
                            words_left <= n_words;
                            carry      <= sub;
                            carry_out  <= 1'b0;
`ifdef MP_ADD_OVF_EN
                            ovf_pend   <= 1'b0;
                            ovf_q      <= 1'b0;
`endif
                            state      <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (xfer) begin
                        out_sum    <= sum_w;
                        out_last   <= (words_left == CNT_W'(1));
                        out_valid  <= 1'b1;
                        carry      <= cout_w;
                        words_left <= words_left - CNT_W'(1);
                        if (words_left == CNT_W'(1)) begin
                            state <= DRAIN;
`ifdef MP_ADD_OVF_EN
                            ovf_pend <= (in_a[WORD_W-1] == b_eff[WORD_W-1]) &&
                                        (sum_w[WORD_W-1] != in_a[WORD_W-1]);
`endif
                        end
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready && out_last) begin
                        out_valid <= 1'b0;
                        carry_out <= carry;
`ifdef MP_ADD_OVF_EN
                        ovf_q     <= ovf_pend;
`endif
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq: full-width arithmetic reference model,
// per-cycle output compare, plus literal expectations from worked examples.
module tb_mp_add_seq;

    localparam int WORD_W    = 32;
    localparam int MAX_WORDS = 8;
    localparam int CNT_W     = $clog2(MAX_WORDS + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [CNT_W-1:0]  n_words;
    logic              sub;
    logic              busy;
    logic              cfg_err;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_a;
    logic [WORD_W-1:0] in_b;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [WORD_W-1:0] out_sum;
    logic              out_last;
    logic              done;
    logic              carry_out;
    logic              ovf;

    mp_add_seq #(.MAX_WORDS(MAX_WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n_words   (n_words),
        .sub       (sub),
        .busy      (busy),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .done      (done),
        .carry_out (carry_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WORD_W-1:0] va [MAX_WORDS];
    logic [WORD_W-1:0] vb [MAX_WORDS];
    logic [WORD_W:0]   exp_q [$];
    logic [WORD_W-1:0] obs [$];
    logic              exp_carry;
    logic              exp_ovf;
    int                done_cnt   = 0;
    int                stall_left = 0;
    bit                hold_pending = 1'b0;
    logic [WORD_W:0]   hold_word;
    logic [WORD_W:0]   exp_word;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: whole-operand arithmetic, then split into words.
    task automatic model_push(input int n, input bit s);
        logic [287:0] a_full, b_full, mask, total;
        a_full = '0;
        b_full = '0;
        for (int i = 0; i < n; i++) begin
            a_full[32*i +: 32] = va[i];
            b_full[32*i +: 32] = vb[i];
        end
        mask = (288'd1 << (32 * n)) - 288'd1;
        if (s) b_full = ~b_full & mask;
        total = a_full + b_full + 288'(s);
        for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), total[32*i +: 32]});
        exp_carry = total[32*n];
`ifdef MP_ADD_OVF_EN
        exp_ovf = (a_full[32*n-1] == b_full[32*n-1]) && (total[32*n-1] != a_full[32*n-1]);
`else
        exp_ovf = 1'b0;
`endif
    endtask

    // Compare process: every accepted output word against the model queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (hold_pending) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_word", 64'({out_last, out_sum}), 64'(hold_word));
            end
            hold_pending = 1'b0;
            if (out_valid && !out_ready) begin
                check("in_ready_backpressure", 64'(in_ready), 64'd0);
                hold_pending = 1'b1;
                hold_word    = {out_last, out_sum};
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'd1, 64'd0);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("word", 64'({out_last, out_sum}), 64'(exp_word));
                    obs.push_back(out_sum);
                end
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (stall_left > 0) begin
            out_ready  = 1'b0;
            stall_left = stall_left - 1;
        end else begin
            out_ready = 1'b1;
        end
    end

    task automatic do_start(input int n, input bit s);
        start   = 1'b1;
        n_words = CNT_W'(n);
        sub     = s;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic feed_word(input string tag, input int i);
        bit taken;
        taken    = 1'b0;
        in_valid = 1'b1;
        in_a     = va[i];
        in_b     = vb[i];
        for (int t = 0; t < 50 && !taken; t++) begin
            @(negedge clk);
            taken = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!taken) check({tag, "_in_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic run_op(input string tag, input int n, input bit s,
                          input int stall_after, input bit poke_busy);
        int dc0;
        bit seen;
        obs.delete();
        model_push(n, s);
        dc0 = done_cnt;
        do_start(n, s);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        if (poke_busy) begin
            start   = 1'b1;
            n_words = '0;
            @(posedge clk);
            #1;
            start = 1'b0;
            check({tag, "_start_while_busy"}, 64'(cfg_err), 64'd0);
        end
        for (int i = 0; i < n; i++) begin
            feed_word(tag, i);
            if (i == stall_after) stall_left = 3;
        end
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            seen = done;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_carry_out"}, 64'(carry_out), 64'(exp_carry));
        check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
        @(posedge clk);
        #1;
        check({tag, "_done_once"}, 64'(done_cnt), 64'(dc0 + 1));
        check({tag, "_word_count"}, 64'(obs.size()), 64'(n));
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int dc0;
        rst_n = 1'b0; start = 1'b0; n_words = '0; sub = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", 64'({busy, cfg_err, in_ready, out_valid, out_last, done,
                                  carry_out, ovf, out_sum}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-word add with carry out of the top bit.
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0000_0001;
        run_op("t1", 1, 1'b0, -1, 1'b0);
        check("t1_lit_sum0", 64'(obs[0]), 64'h0);
        check("t1_lit_carry", 64'(carry_out), 64'd1);

        // 64-bit carry chain across the word boundary; start while busy is ignored.
        va[0] = 32'hFFFF_FFFF; va[1] = 32'h0;
        vb[0] = 32'h0000_0001; vb[1] = 32'h0;
        run_op("t2", 2, 1'b0, -1, 1'b1);
        check("t2_lit_sum0", 64'(obs[0]), 64'h0);
        check("t2_lit_sum1", 64'(obs[1]), 64'h1);
        check("t2_lit_carry", 64'(carry_out), 64'd0);

        // 96-bit 1 - 2: borrow ripples through every word.
        va[0] = 32'h1; va[1] = 32'h0; va[2] = 32'h0;
        vb[0] = 32'h2; vb[1] = 32'h0; vb[2] = 32'h0;
        run_op("t3", 3, 1'b1, -1, 1'b0);
        for (int i = 0; i < 3; i++) check("t3_lit_sum", 64'(obs[i]), 64'hFFFF_FFFF);
        check("t3_lit_carry", 64'(carry_out), 64'd0);
        check("t3_lit_ovf", 64'(ovf), 64'd0);

        // Four words with a 3-cycle downstream stall after the second word.
        va[0] = 32'h89AB_CDEF; va[1] = 32'h1234_5678; va[2] = 32'hF0F0_F0F0; va[3] = 32'h8000_0000;
        vb[0] = 32'h7654_3211; vb[1] = 32'hEDCB_A987; vb[2] = 32'h0F0F_0F0F; vb[3] = 32'h8000_0000;
        run_op("t4", 4, 1'b0, 1, 1'b0);
        check("t4_lit_sum0", 64'(obs[0]), 64'h0);
        check("t4_lit_sum1", 64'(obs[1]), 64'h0);
        check("t4_lit_sum2", 64'(obs[2]), 64'h0);
        check("t4_lit_sum3", 64'(obs[3]), 64'h1);
        check("t4_lit_carry", 64'(carry_out), 64'd1);

        // Rejected starts: zero words, then more than MAX_WORDS.
        do_start(0, 1'b0);
        check("cfg0_err", 64'({cfg_err, busy}), 64'b10);
        @(posedge clk);
        #1;
        check("cfg0_err_clear", 64'(cfg_err), 64'd0);
        do_start(9, 1'b0);
        check("cfg9_err", 64'({cfg_err, busy}), 64'b10);
        @(posedge clk);
        #1;
        check("cfg9_err_clear", 64'({cfg_err, busy}), 64'd0);

        // Signed overflow of the largest positive value plus one.
        va[0] = 32'h7FFF_FFFF; vb[0] = 32'h0000_0001;
        run_op("t6", 1, 1'b0, -1, 1'b0);
        check("t6_lit_sum0", 64'(obs[0]), 64'h8000_0000);
        check("t6_lit_carry", 64'(carry_out), 64'd0);
`ifdef MP_ADD_OVF_EN
        check("t6_lit_ovf", 64'(ovf), 64'd1);
`else
        check("t6_lit_ovf", 64'(ovf), 64'd0);
`endif

        // Reset part-way through a four-word operation.
        for (int i = 0; i < 4; i++) begin
            va[i] = 32'h1111_1111 * (i + 1);
            vb[i] = 32'h0101_0101;
        end
        obs.delete();
        model_push(4, 1'b0);
        dc0 = done_cnt;
        do_start(4, 1'b0);
        feed_word("t7", 0);
        feed_word("t7", 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t7_reset_outputs", 64'({busy, cfg_err, in_ready, out_valid, out_last, done,
                                       carry_out, ovf, out_sum}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        repeat (4) @(posedge clk);
        #1;
        check("t7_no_done", 64'(done_cnt), 64'(dc0));
        check("t7_idle", 64'(busy), 64'd0);

        // Recovery after reset: 5 - 3 with no borrow.
        va[0] = 32'h5; vb[0] = 32'h3;
        run_op("t8", 1, 1'b1, -1, 1'b0);
        check("t8_lit_sum0", 64'(obs[0]), 64'h2);
        check("t8_lit_carry", 64'(carry_out), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
